// File: rtl/operand_exec_seq_if.sv
// operand_exec_seq_if: command, register-file and status signals of the operand/execute sequencer
interface operand_exec_seq_if #(parameter int DW = 16, parameter int RW = 3);
  logic          start;
  logic [RW-1:0] rn;
  logic [RW-1:0] rm;
  logic [RW-1:0] rd;
  logic [1:0]    shift;
  logic [1:0]    aluop;
  logic          wb_en;
  logic [DW-1:0] rf_data;
  logic [RW-1:0] readnum;
  logic [RW-1:0] writenum;
  logic          write;
  logic [DW-1:0] data_in;
  logic          busy;
  logic          done;
  logic [2:0]    status;
  modport slave (
    input  start, rn, rm, rd, shift, aluop, wb_en, rf_data,
    output readnum, writenum, write, data_in, busy, done, status
  );
  modport master (
    output start, rn, rm, rd, shift, aluop, wb_en, rf_data,
    input  readnum, writenum, write, data_in, busy, done, status
  );
endinterface

// File: rtl/operand_exec_seq.sv
// operand_exec_seq: reads Rn/Rm from the register file, shifts Rm, runs the ALU and writes C back to Rd
module operand_exec_seq #(parameter int DW = 16, parameter int RW = 3) (
  input logic clk,
  input logic reset,
  operand_exec_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LD_A, LD_B, EXEC, WB, DONE} state_t;
  state_t state, state_n;
  logic [RW-1:0] rn_q, rm_q, rd_q;
  logic [1:0] shift_q, aluop_q;
  logic wb_en_q;
  logic [DW-1:0] a, b, c, bs, b2, sum, res;
  logic [2:0] status_q;
  logic sub, v;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.start ? LD_A : IDLE;
      LD_A:    state_n = LD_B;
      LD_B:    state_n = EXEC;
      EXEC:    state_n = WB;
      WB:      state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    bs = shift_q == 2'b01 ? {b[DW-2:0], 1'b0} :
         shift_q == 2'b10 ? {1'b0, b[DW-1:1]} :
         shift_q == 2'b11 ? {b[DW-1], b[DW-1:1]} : b;
    sub = aluop_q == 2'b01;
    b2 = sub ? ~bs : bs;
    sum = a + b2 + {{(DW-1){1'b0}}, sub};
    res = aluop_q[1] ? (aluop_q[0] ? ~bs : a & bs) : sum;
    // Overflow: operands of equal sign producing a result of the other sign; sub uses the inverted operand
    v = !aluop_q[1] && (a[DW-1] == b2[DW-1]) && (sum[DW-1] != a[DW-1]);
  end
  always_ff @(posedge clk)
    if (reset) begin
      {rn_q, rm_q, rd_q, shift_q, aluop_q, wb_en_q} <= '0;
      a <= '0;
      b <= '0;
      c <= '0;
      status_q <= '0;
    end else begin
      if (state == IDLE && bus.start)
        {rn_q, rm_q, rd_q, shift_q, aluop_q, wb_en_q} <= {bus.rn, bus.rm, bus.rd, bus.shift, bus.aluop, bus.wb_en};
      if (state == LD_A) a <= bus.rf_data;
      if (state == LD_B) b <= bus.rf_data;
      if (state == EXEC) begin
        c <= res;
        status_q <= {res[DW-1], v, res == '0};
      end
    end
  always_comb begin
    bus.readnum = state == LD_A ? rn_q : state == LD_B ? rm_q : '0;
    bus.writenum = state == WB ? rd_q : '0;
    bus.write = state == WB && wb_en_q;
    bus.data_in = c;
    bus.busy = state != IDLE;
    bus.done = state == DONE;
    bus.status = status_q;
  end
endmodule

// File: tb/tb_operand_exec_seq.sv
// tb_operand_exec_seq: directed checks of the sequencer against a behavioural 8x16 register file
module tb_operand_exec_seq;
  logic clk = 0;
  logic reset = 1;
  int nvec = 0;
  int nerr = 0;
  int wr_cnt = 0;
  logic [15:0] rf [8];
  operand_exec_seq_if #(.DW(16), .RW(3)) bus ();
  operand_exec_seq #(.DW(16), .RW(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.rf_data = rf[bus.readnum];
  always @(posedge clk) begin
    if (bus.write) rf[bus.writenum] <= bus.data_in;
    if (bus.write) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                       input logic [1:0] sh, input logic [1:0] op, input logic wb);
    bus.rn = rn; bus.rm = rm; bus.rd = rd; bus.shift = sh; bus.aluop = op; bus.wb_en = wb;
    bus.start = 1;
  endtask

  task automatic run_cmd(input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                         input logic [1:0] sh, input logic [1:0] op, input logic wb, output int lat);
    drive(rn, rm, rd, sh, op, wb);
    @(posedge clk); #1;
    bus.start = 0;
    bus.rn = 'x; bus.rm = 'x; bus.rd = 'x; bus.shift = 'x; bus.aluop = 'x; bus.wb_en = 'x;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_write", bus.write, 0);
    chk("rst_readnum", bus.readnum, 0);
    chk("rst_writenum", bus.writenum, 0);
    chk("rst_status", bus.status, 0);
    chk("rst_data_in", bus.data_in, 0);
    reset = 0;
  endtask

  task automatic test_add;
    int lat;
    int w0;
    rf[1] = 16'd5; rf[2] = 16'd3; rf[3] = 16'hAAAA;
    w0 = wr_cnt;
    drive(1, 2, 3, 2'b00, 2'b00, 1);
    @(posedge clk); #1;
    bus.start = 0;
    chk("add_ld_a_readnum", bus.readnum, 1);
    @(posedge clk); #1;
    chk("add_ld_b_readnum", bus.readnum, 2);
    @(posedge clk); #1;
    chk("add_exec_readnum", bus.readnum, 0);
    @(posedge clk); #1;
    chk("add_wb_writenum", bus.writenum, 3);
    chk("add_wb_write", bus.write, 1);
    chk("add_wb_data_in", bus.data_in, 16'd8);
    @(posedge clk); #1;
    chk("add_done", bus.done, 1);
    chk("add_r3", rf[3], 16'd8);
    chk("add_status", bus.status, 3'b000);
    @(posedge clk); #1;
    chk("add_done_pulse", bus.done, 0);
    chk("add_idle_busy", bus.busy, 0);
    chk("add_write_count", wr_cnt - w0, 1);
    run_cmd(1, 2, 4, 2'b00, 2'b00, 1, lat);
    chk("add_latency", lat, 4);
  endtask

  task automatic test_compare;
    int lat;
    int w0;
    logic [15:0] snap [8];
    for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
    rf[1] = 16'h0004; rf[2] = 16'h0004;
    snap = rf;
    w0 = wr_cnt;
    run_cmd(1, 2, 3, 2'b00, 2'b01, 0, lat);
    chk("cmp_latency", lat, 4);
    chk("cmp_status", bus.status, 3'b001);
    chk("cmp_no_write", wr_cnt - w0, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("cmp_r%0d", i), rf[i], snap[i]);
  endtask

  task automatic test_overflow;
    int lat;
    rf[4] = 16'h7FFF; rf[5] = 16'h0001;
    run_cmd(4, 5, 6, 2'b00, 2'b00, 1, lat);
    chk("ovf_r6", rf[6], 16'h8000);
    chk("ovf_status", bus.status, 3'b110);
    rf[4] = 16'h0000; rf[5] = 16'h8000;
    run_cmd(4, 5, 7, 2'b00, 2'b01, 1, lat);
    chk("subovf_r7", rf[7], 16'h8000);
    chk("subovf_status", bus.status, 3'b110);
    rf[4] = 16'h00F0; rf[5] = 16'h0F3C;
    run_cmd(4, 5, 7, 2'b00, 2'b10, 1, lat);
    chk("and_r7", rf[7], 16'h0030);
    chk("and_status", bus.status, 3'b000);
  endtask

  task automatic test_asr_rd_eq_rm;
    int lat;
    rf[0] = 16'h1111; rf[2] = 16'h8002;
    run_cmd(0, 2, 2, 2'b11, 2'b11, 1, lat);
    chk("asr_r2", rf[2], 16'h3FFE);
    chk("asr_status", bus.status, 3'b000);
    chk("asr_r0", rf[0], 16'h1111);
  endtask

  task automatic test_shift_sweep;
    int lat;
    rf[7] = 16'h8001;
    run_cmd(0, 7, 1, 2'b00, 2'b11, 1, lat);
    chk("sweep_none", rf[1], 16'h7FFE);
    chk("sweep_none_status", bus.status, 3'b000);
    run_cmd(0, 7, 1, 2'b01, 2'b11, 1, lat);
    chk("sweep_lsl", rf[1], 16'hFFFD);
    chk("sweep_lsl_status", bus.status, 3'b100);
    run_cmd(0, 7, 1, 2'b10, 2'b11, 1, lat);
    chk("sweep_lsr", rf[1], 16'hBFFF);
    chk("sweep_lsr_status", bus.status, 3'b100);
  endtask

  task automatic test_abort;
    int w0;
    int dones = 0;
    rf[1] = 16'd5; rf[2] = 16'd3; rf[3] = 16'h1234;
    w0 = wr_cnt;
    drive(1, 2, 3, 2'b00, 2'b00, 1);
    @(posedge clk); #1;
    bus.start = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_exec_busy", bus.busy, 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_status", bus.status, 3'b000);
    repeat (6) begin
      if (bus.done) dones++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_r3", rf[3], 16'h1234);
    chk("abort_no_write", wr_cnt - w0, 0);
  endtask

  task automatic test_start_held;
    int w0;
    int lat = 0;
    rf[3] = 16'h0011; rf[5] = 16'h0000;
    w0 = wr_cnt;
    drive(3, 3, 5, 2'b00, 2'b00, 1);
    @(posedge clk); #1;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("held_latency", lat, 4);
    bus.start = 0;
    @(posedge clk); #1;
    chk("held_idle", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("held_r5", rf[5], 16'h0022);
    chk("held_one_write", wr_cnt - w0, 1);
  endtask

  task automatic test_back_to_back;
    int lat = 0;
    rf[1] = 16'd10; rf[2] = 16'd7;
    drive(1, 2, 4, 2'b00, 2'b01, 1);
    @(posedge clk); #1;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_first_latency", lat, 4);
    bus.rd = 6; bus.aluop = 2'b00;
    @(posedge clk); #1;
    chk("b2b_done_start_ignored", bus.busy, 0);
    @(posedge clk); #1;
    chk("b2b_second_accept", bus.busy, 1);
    chk("b2b_second_readnum", bus.readnum, 1);
    bus.start = 0;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_second_latency", lat, 4);
    chk("b2b_r4", rf[4], 16'd3);
    chk("b2b_r6", rf[6], 16'd17);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.start = 0; bus.rn = 0; bus.rm = 0; bus.rd = 0; bus.shift = 0; bus.aluop = 0; bus.wb_en = 0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    test_reset;
    test_add;
    test_compare;
    test_overflow;
    test_asr_rd_eq_rm;
    test_shift_sweep;
    test_abort;
    test_start_held;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
